// File: rtl/clkgen_cfg_if.sv
// Configuration request channel between a requester and the clock-generator config sequencer.
interface clkgen_cfg_if;
    logic       CFG_VALID;
    logic       CFG_READY;
    logic [1:0] CFG_FREQ;
    logic [2:0] CFG_PHASE;
    logic [2:0] CFG_DUTY;
    logic       CFG_ERR;

    modport master (
        output CFG_VALID, CFG_FREQ, CFG_PHASE, CFG_DUTY,
        input  CFG_READY, CFG_ERR
    );

    modport slave (
        input  CFG_VALID, CFG_FREQ, CFG_PHASE, CFG_DUTY,
        output CFG_READY, CFG_ERR
    );
endinterface

// File: rtl/clkgen_cfg_sequencer.sv
// Lock-qualified, glitch-safe application of frequency/phase/duty selects:
// gate outputs, drain, switch all selects together, settle, re-enable.
module clkgen_cfg_sequencer #(
    parameter int QUIESCE_CYCLES = 16,
    parameter int SETTLE_CYCLES  = 64,
    parameter int LOCK_QUAL      = 4
) (
    input  logic           USER_CLOCK,
    input  logic           RESET,
    input  logic           LOCKED,
    clkgen_cfg_if.slave    cfg,
    output logic [1:0]     FREQ_SEL,
    output logic [2:0]     PHASE_SEL,
    output logic [2:0]     DUTY_SEL,
    output logic           CLK_EN,
    output logic           BUSY
);

    localparam int QS_MAX  = (QUIESCE_CYCLES > SETTLE_CYCLES) ? QUIESCE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_MAX = (QS_MAX > LOCK_QUAL) ? QS_MAX : LOCK_QUAL;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_QUAL - 1);
    localparam logic [CNT_W-1:0] QUIESCE_LAST = CNT_W'(QUIESCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        IDLE,
        QUIESCE,
        APPLY,
        SETTLE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic             lock_meta, lock_s;

    logic [1:0]       pend_freq;
    logic [2:0]       pend_phase;
    logic [2:0]       pend_duty;

    logic             xfer;
    logic             req_illegal;
    logic             req_same;
    logic             pend_ld;
    logic             sel_ld;
    logic             err_set;

    // LOCKED comes from another clock domain's lock detector.
    always_ff @(posedge USER_CLOCK) begin
        if (RESET) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= LOCKED;
            lock_s    <= lock_meta;
        end
    end

    assign xfer        = cfg.CFG_VALID & cfg.CFG_READY;
    assign req_illegal = (cfg.CFG_FREQ == 2'd3);
    assign req_same    = ({cfg.CFG_FREQ, cfg.CFG_PHASE, cfg.CFG_DUTY} ==
                          {FREQ_SEL, PHASE_SEL, DUTY_SEL});

    always_ff @(posedge USER_CLOCK) begin
        if (RESET) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // One shared counter: each state that times something starts it at zero,
    // and it only ever counts up to that state's last value.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_ld   = 1'b0;
        sel_ld    = 1'b0;
        err_set   = 1'b0;

        case (state)
            WAIT_LOCK: begin
                if (!lock_s) begin
                    cnt_nxt = '0;
                end else if (cnt == LOCK_LAST) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            IDLE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (xfer) begin
                    if (req_illegal) begin
                        err_set = 1'b1;
                    end else if (!req_same) begin
                        pend_ld   = 1'b1;
                        state_nxt = QUIESCE;
                        cnt_nxt   = '0;
                    end
                end
            end

            QUIESCE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == QUIESCE_LAST) begin
                    state_nxt = APPLY;
                    sel_ld    = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            APPLY: begin
                state_nxt = lock_s ? SETTLE : WAIT_LOCK;
                cnt_nxt   = '0;
            end

            SETTLE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == SETTLE_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            default: begin
                state_nxt = WAIT_LOCK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge USER_CLOCK) begin
        if (RESET) begin
            FREQ_SEL      <= '0;
            PHASE_SEL     <= '0;
            DUTY_SEL      <= '0;
            CLK_EN        <= 1'b0;
            BUSY          <= 1'b1;
            cfg.CFG_READY <= 1'b0;
            cfg.CFG_ERR   <= 1'b0;
            pend_freq     <= '0;
            pend_phase    <= '0;
            pend_duty     <= '0;
        end else begin
            CLK_EN        <= (state_nxt == IDLE);
            BUSY          <= (state_nxt != IDLE);
            cfg.CFG_READY <= (state_nxt == IDLE);
            if (err_set)
                cfg.CFG_ERR <= 1'b1;
            if (pend_ld) begin
                pend_freq  <= cfg.CFG_FREQ;
                pend_phase <= cfg.CFG_PHASE;
                pend_duty  <= cfg.CFG_DUTY;
            end
            if (sel_ld) begin
                FREQ_SEL  <= pend_freq;
                PHASE_SEL <= pend_phase;
                DUTY_SEL  <= pend_duty;
            end
        end
    end

endmodule

// File: doc/clkgen_cfg_sequencer.md
# clkgen_cfg_sequencer

Configuration front-end for the high-frequency clock generator path. Accepts frequency/phase/duty selection requests over a valid/ready handshake, holds them until the DCM reports lock, and applies them safely. On each change it gates the modulated clock outputs off, waits for the old waveform to drain, switches `FREQ_SEL`/`PHASE_SEL`/`DUTY_SEL` atomically, then waits for the new waveform to settle before re-enabling. It sits directly upstream of the frequency mux and the non-overlapping clock generator and drives their select inputs plus an output-enable.

## Interface
- `QUIESCE_CYCLES`, 16: cycles outputs stay gated before selects change (≥1).
- `SETTLE_CYCLES`, 64: cycles after the select change before re-enable (≥1).
- `LOCK_QUAL`, 4: consecutive `LOCKED`=1 samples required to qualify lock (≥1).
- `USER_CLOCK`  in  1  single block clock; all logic on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `LOCKED`  in  1  DCM lock from the clock-generation stage; treat as asynchronous; 2-flop synchronised before use.
- `CFG_VALID`  in  1  request valid.
- `CFG_READY`  out  1  block can accept a request.
- `CFG_FREQ`  in  2  requested frequency: 0=10 MHz, 1=25 MHz, 2=50 MHz, 3=illegal.
- `CFG_PHASE`  in  3  requested phase code.
- `CFG_DUTY`  in  3  requested duty code.
- `FREQ_SEL`  out  2  applied frequency select.
- `PHASE_SEL`  out  3  applied phase select.
- `DUTY_SEL`  out  3  applied duty select.
- `CLK_EN`  out  1  enable for modulated clock outputs (1 = run).
- `BUSY`  out  1  high in any state other than IDLE.
- `CFG_ERR`  out  1  sticky flag: an illegal request was received.

## Operation
- All outputs are registered. Reset values: `FREQ_SEL`=0, `PHASE_SEL`=0, `DUTY_SEL`=0, `CLK_EN`=0, `CFG_READY`=0, `BUSY`=1, `CFG_ERR`=0. State after reset is WAIT_LOCK.
- States: WAIT_LOCK, IDLE, QUIESCE, APPLY, SETTLE.
- WAIT_LOCK:
  - Lock counter increments on each synchronised `LOCKED`=1 sample and clears on any 0 sample.
  - When the counter reaches `LOCK_QUAL`, go to SETTLE.
- IDLE:
  - `CFG_READY`=1, `CLK_EN`=1.
  - A transfer occurs on an edge with `CFG_VALID`&`CFG_READY`.
- On a transfer:
  - If `CFG_FREQ`=3: set `CFG_ERR` and stay in IDLE. The request is consumed and the selects are unchanged.
  - If the request equals the current selects: consume it and stay in IDLE with no gating.
  - Otherwise: latch the request into a pending register, drive `CLK_EN`←0 and `CFG_READY`←0, and go to QUIESCE.
- QUIESCE: hold for `QUIESCE_CYCLES` edges, then go to APPLY. At that same edge, all three selects load from the pending register together.
- APPLY: one cycle, then go to SETTLE.
- SETTLE: hold for `SETTLE_CYCLES` edges, then go to IDLE with `CLK_EN`←1 and `CFG_READY`←1.
- Lock loss:
  - Synchronised `LOCKED`=0 in IDLE, QUIESCE, APPLY or SETTLE forces WAIT_LOCK with `CLK_EN`←0 and `CFG_READY`←0.
  - The selects keep their current values. A pending request not yet applied is discarded.
- `CFG_ERR` clears only on `RESET`.
- `RESET` mid-sequence returns to the reset values on the next edge, regardless of state.
- Counter widths are sized from the parameters. Counters must not wrap.

## Timing
- Edge numbering for config changes: edge 0 is the accepting edge.
  - `CLK_EN`=0 from edge 0.
  - Selects change at edge `QUIESCE_CYCLES`.
  - `CLK_EN`=1 and `CFG_READY`=1 at edge `QUIESCE_CYCLES`+1+`SETTLE_CYCLES`.
  - With defaults: selects change at edge 16, re-enable at edge 81.
- Power-up: with synchronised `LOCKED` high from the first post-reset edge, SETTLE is entered at edge `LOCK_QUAL` and IDLE at edge `LOCK_QUAL`+`SETTLE_CYCLES`. With defaults, IDLE is reached at edge 68, counted from the first synchronised high sample.
- `CLK_EN` is never high while any select differs from its value at the last IDLE entry.
- Illegal and identical requests: `CFG_READY` stays high, so back-to-back requests are accepted on consecutive edges.
- `CFG_VALID` arriving while `CFG_READY`=0 is ignored. It is not queued, and the requester must hold it.

## Test plan
- Reset, then `LOCKED`=1 steady → `CLK_EN`/`CFG_READY` rise exactly `LOCK_QUAL`+`SETTLE_CYCLES`=68 edges after synchronised lock. Selects are 0/0/0.
- In IDLE, request FREQ=2, PHASE=5, DUTY=3 → `CLK_EN` drops at edge 0, selects become 2/5/3 at edge 16, `CLK_EN`=1 at edge 81, `BUSY` is high throughout.
- Request FREQ=3 → `CFG_ERR`=1 and stays set through later legal requests. Selects are unchanged and `CLK_EN` never drops.
- Request equal to the current selects → accepted in one cycle, `CLK_EN` stays 1, no state change.
- Drop `LOCKED` at QUIESCE edge 5 → WAIT_LOCK, pending discarded, old selects retained. After relock: 68 edges to IDLE with the old selects.
- Assert `RESET` during SETTLE → next edge shows all reset values. `CFG_VALID` held high during `CFG_READY`=0 is not accepted until IDLE.
